// File: rtl/complex_matmul_sequencer.sv
// Streams in two 4x4 complex matrices (A then B, row-major), computes C = A x B
// with a single complex multiply-accumulate, and streams the 16 results out.
module complex_matmul_sequencer #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 2*DATA_W+3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_re,
    output logic [OUT_W-1:0]  out_im,
    output logic              out_last,
    output logic              busy
);

    // Handshakes: a beat transfers on a rising edge where valid && ready are both
    // high; the producer holds data stable while valid is high and ready is low.

    localparam int PW = 2*DATA_W;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_EMIT    = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] a_re_q [16];
    logic [DATA_W-1:0] a_im_q [16];
    logic [DATA_W-1:0] b_re_q [16];
    logic [DATA_W-1:0] b_im_q [16];

    logic [4:0] beat_q;
    logic [1:0] i_q, j_q, k_q;

    logic signed [OUT_W-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;
    logic [OUT_W-1:0]        out_re_q, out_im_q;
    logic                    out_valid_q, out_last_q;

    logic in_fire, out_fire, last_elem;

    assign in_fire   = in_valid && (state_q == ST_LOAD);
    assign out_fire  = out_ready && out_valid_q && (state_q == ST_EMIT);
    assign last_elem = (i_q == 2'd3) && (j_q == 2'd3);

    function automatic logic signed [PW-1:0] ext_pw(input logic [DATA_W-1:0] x);
        return {{(PW-DATA_W){x[DATA_W-1]}}, x};
    endfunction

    function automatic logic signed [OUT_W-1:0] ext_out(input logic [PW-1:0] x);
        return {{(OUT_W-PW){x[PW-1]}}, x};
    endfunction

    logic [3:0] a_idx, b_idx;
    logic signed [PW-1:0] ar, ai, br, bi;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [OUT_W-1:0] p_re, p_im;

    assign a_idx = {i_q, k_q};
    assign b_idx = {k_q, j_q};
    assign ar    = ext_pw(a_re_q[a_idx]);
    assign ai    = ext_pw(a_im_q[a_idx]);
    assign br    = ext_pw(b_re_q[b_idx]);
    assign bi    = ext_pw(b_im_q[b_idx]);
    assign p_rr  = ar * br;
    assign p_ii  = ai * bi;
    assign p_ri  = ar * bi;
    assign p_ir  = ai * br;
    assign p_re  = ext_out(p_rr) - ext_out(p_ii);
    assign p_im  = ext_out(p_ri) + ext_out(p_ir);

    always_comb begin
        acc_re_d = p_re;
        acc_im_d = p_im;
        if (k_q != 2'd0) begin
            acc_re_d = acc_re_q + p_re;
            acc_im_d = acc_im_q + p_im;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:    if (in_fire && (beat_q == 5'd31)) state_d = ST_COMPUTE;
            ST_COMPUTE: if (k_q == 2'd3) state_d = ST_EMIT;
            ST_EMIT:    if (out_fire) state_d = last_elem ? ST_LOAD : ST_COMPUTE;
            default:    state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_LOAD);
        busy     = (state_q != ST_LOAD);
    end

    // Matrix storage has no reset: contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            if (!beat_q[4]) begin
                a_re_q[beat_q[3:0]] <= in_re;
                a_im_q[beat_q[3:0]] <= in_im;
            end else begin
                b_re_q[beat_q[3:0]] <= in_re;
                b_im_q[beat_q[3:0]] <= in_im;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_q      <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_fire) begin
                        beat_q <= beat_q + 5'd1;
                        i_q    <= '0;
                        j_q    <= '0;
                        k_q    <= '0;
                    end
                end
                ST_COMPUTE: begin
                    acc_re_q <= acc_re_d;
                    acc_im_q <= acc_im_d;
                    k_q      <= k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        out_re_q    <= acc_re_d;
                        out_im_q    <= acc_im_d;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_elem;
                    end
                end
                ST_EMIT: begin
                    if (out_fire) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        k_q         <= '0;
                        if (last_elem) begin
                            beat_q <= '0;
                        end else begin
                            j_q <= j_q + 2'd1;
                            if (j_q == 2'd3) i_q <= i_q + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_complex_matmul_sequencer.sv
// Directed bench for complex_matmul_sequencer: loads matrix pairs, checks every
// result beat against an expected queue, plus latency, backpressure and reset abort.
module tb_complex_matmul_sequencer;

  localparam int DATA_W = 16;
  localparam int OUT_W  = 2*DATA_W+3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_im;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_re;
  logic [OUT_W-1:0]  out_im;
  logic              out_last;
  logic              busy;

  complex_matmul_sequencer #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got time limit, expected completion");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  int a_re [16];
  int a_im [16];
  int b_re [16];
  int b_im [16];

  logic [OUT_W-1:0] exp_re_q [$];
  logic [OUT_W-1:0] exp_im_q [$];
  logic             exp_last_q [$];

  int t_accept;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus / scoreboard helpers ----------------
  task automatic push_exp(input longint re, input longint im, input bit last);
    exp_re_q.push_back(OUT_W'(re));
    exp_im_q.push_back(OUT_W'(im));
    exp_last_q.push_back(last);
  endtask

  task automatic build_model();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        longint sr = 0;
        longint si = 0;
        for (int k = 0; k < 4; k++) begin
          longint ar = a_re[i*4+k];
          longint ai = a_im[i*4+k];
          longint br = b_re[k*4+j];
          longint bi = b_im[k*4+j];
          sr += ar*br - ai*bi;
          si += ar*bi + ai*br;
        end
        push_exp(sr, si, (i == 3) && (j == 3));
      end
    end
  endtask

  task automatic clear_exp();
    exp_re_q.delete();
    exp_im_q.delete();
    exp_last_q.delete();
  endtask

  task automatic set_identity_a();
    for (int n = 0; n < 16; n++) begin
      a_re[n] = (n % 5 == 0) ? 1 : 0;
      a_im[n] = 0;
    end
  endtask

  task automatic set_ramp_b();
    for (int n = 0; n < 16; n++) begin
      b_re[n] = n + 1;
      b_im[n] = -n;
    end
  endtask

  task automatic push_ramp_b_exp();
    for (int n = 0; n < 16; n++) push_exp(longint'(n + 1), -longint'(n), n == 15);
  endtask

  task automatic load_pair(input bit bubbles, output int t_first_o);
    int idx = 0;
    int guard = 0;
    t_first_o = -1;
    while (idx < 32 && guard < 500) begin
      guard++;
      if (bubbles && (cyc % 3 == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        if (idx < 16) begin
          in_re = DATA_W'(a_re[idx]);
          in_im = DATA_W'(a_im[idx]);
        end else begin
          in_re = DATA_W'(b_re[idx-16]);
          in_im = DATA_W'(b_im[idx-16]);
        end
      end
      if (in_valid && in_ready) begin
        if (idx == 0) t_first_o = cyc;
        if (idx == 31) t_accept = cyc;
        idx++;
      end
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (idx !== 32) begin
      n_fail++;
      $display("FAIL load_timeout: got %0d beats accepted, expected 32", idx);
    end
  endtask

  task automatic collect(input string name, input int n, input bit rand_ready,
                         input bit check_gap, output int first_valid_o);
    int got = 0;
    int guard = 0;
    int last_hs = -1;
    bit stalled = 1'b0;
    logic [OUT_W-1:0] held_re, held_im;
    logic held_last;
    first_valid_o = -1;
    while (got < n && guard < 3000) begin
      guard++;
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_re !== held_re || out_im !== held_im || out_last !== held_last) begin
          n_fail++;
          $display("FAIL %s_stall_hold: got v=%0b re=%0d im=%0d last=%0b, expected v=1 re=%0d im=%0d last=%0b",
                   name, out_valid, $signed(out_re), $signed(out_im), out_last,
                   $signed(held_re), $signed(held_im), held_last);
        end
      end
      if (out_valid === 1'b1) begin
        if (first_valid_o < 0) first_valid_o = cyc;
        if (out_ready) begin
          n_checks++;
          if (exp_re_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_extra_beat: got re=%0d im=%0d, expected no beat", name,
                     $signed(out_re), $signed(out_im));
          end else begin
            logic [OUT_W-1:0] er, ei;
            logic el;
            er = exp_re_q.pop_front();
            ei = exp_im_q.pop_front();
            el = exp_last_q.pop_front();
            if (out_re !== er || out_im !== ei || out_last !== el) begin
              n_fail++;
              $display("FAIL %s_beat%0d: got re=%0d im=%0d last=%0b, expected re=%0d im=%0d last=%0b",
                       name, got, $signed(out_re), $signed(out_im), out_last,
                       $signed(er), $signed(ei), el);
            end
          end
          if (check_gap && last_hs >= 0) begin
            n_checks++;
            if (cyc - last_hs !== 5) begin
              n_fail++;
              $display("FAIL %s_gap%0d: got %0d cycles between results, expected 5", name, got, cyc - last_hs);
            end
          end
          last_hs = cyc;
          got++;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          held_re   = out_re;
          held_im   = out_im;
          held_last = out_last;
        end
      end else begin
        stalled = 1'b0;
      end
      step();
    end
    out_ready = 1'b0;
    n_checks++;
    if (got !== n) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d results, expected %0d", name, got, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got in_ready=%0b busy=%0b out_valid=%0b out_last=%0b, expected 1 0 0 0",
               in_ready, busy, out_valid, out_last);
    end
    n_checks++;
    if (out_re !== '0 || out_im !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got re=%0d im=%0d, expected 0 0", $signed(out_re), $signed(out_im));
    end
  endtask

  task automatic test_identity();
    int tf, fv;
    set_identity_a();
    set_ramp_b();
    clear_exp();
    push_ramp_b_exp();
    load_pair(1'b0, tf);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ident_compute_flags: got busy=%0b in_ready=%0b, expected 1 0", busy, in_ready);
    end
    collect("ident", 16, 1'b0, 1'b1, fv);
    n_checks++;
    if (fv - t_accept !== 5) begin
      n_fail++;
      $display("FAIL ident_first_latency: got %0d cycles, expected 5", fv - t_accept);
    end
    n_checks++;
    if (cyc - t_accept !== 81) begin
      n_fail++;
      $display("FAIL ident_total: got final handshake at T+%0d, expected T+80", cyc - t_accept - 1);
    end
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ident_after_last: got in_ready=%0b busy=%0b out_valid=%0b, expected 1 0 0",
               in_ready, busy, out_valid);
    end
  endtask

  task automatic test_min_values();
    int tf, fv;
    for (int n = 0; n < 16; n++) begin
      a_re[n] = -32768; a_im[n] = -32768;
      b_re[n] = -32768; b_im[n] = -32768;
    end
    clear_exp();
    for (int n = 0; n < 16; n++) push_exp(0, 64'sd8589934592, n == 15);
    load_pair(1'b0, tf);
    collect("minval", 16, 1'b0, 1'b0, fv);
  endtask

  task automatic test_real_imag();
    int tf, fv;
    for (int n = 0; n < 16; n++) begin
      a_re[n] = n; a_im[n] = 0;
      b_re[n] = 0; b_im[n] = n;
    end
    clear_exp();
    build_model();
    load_pair(1'b0, tf);
    collect("realimag", 16, 1'b0, 1'b0, fv);
  endtask

  task automatic test_backpressure();
    int tf, fv;
    for (int n = 0; n < 16; n++) begin
      a_re[n] = int'($urandom_range(0, 65535)) - 32768;
      a_im[n] = int'($urandom_range(0, 65535)) - 32768;
      b_re[n] = int'($urandom_range(0, 65535)) - 32768;
      b_im[n] = int'($urandom_range(0, 65535)) - 32768;
    end
    clear_exp();
    build_model();
    load_pair(1'b1, tf);
    collect("bp", 16, 1'b1, 1'b0, fv);
  endtask

  task automatic test_reset_abort();
    int tf, fv;
    for (int n = 0; n < 16; n++) begin
      a_re[n] = n + 3; a_im[n] = -n;
      b_re[n] = 7 - n; b_im[n] = 2 * n;
    end
    clear_exp();
    build_model();
    load_pair(1'b0, tf);
    collect("abort_pre", 6, 1'b0, 1'b0, fv);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after_reset: got in_ready=%0b busy=%0b out_valid=%0b, expected 1 0 0",
               in_ready, busy, out_valid);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_emit: got out_valid=%0b at cycle %0d after reset, expected 0", out_valid, c + 1);
      end
    end
    out_ready = 1'b0;
    set_identity_a();
    set_ramp_b();
    clear_exp();
    push_ramp_b_exp();
    load_pair(1'b0, tf);
    collect("abort_post", 16, 1'b0, 1'b0, fv);
  endtask

  task automatic test_back_to_back();
    int tf, fv, f1;
    for (int n = 0; n < 16; n++) begin
      a_re[n] = int'($urandom_range(0, 200)) - 100;
      a_im[n] = int'($urandom_range(0, 200)) - 100;
      b_re[n] = int'($urandom_range(0, 200)) - 100;
      b_im[n] = int'($urandom_range(0, 200)) - 100;
    end
    clear_exp();
    build_model();
    load_pair(1'b0, tf);
    collect("b2b_first", 16, 1'b0, 1'b0, fv);
    f1 = cyc;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got in_ready=%0b after final handshake, expected 1", in_ready);
    end
    for (int n = 0; n < 16; n++) begin
      a_re[n] = n;  a_im[n] = 1;
      b_re[n] = -n; b_im[n] = n + 2;
    end
    build_model();
    load_pair(1'b0, tf);
    n_checks++;
    if (tf !== f1) begin
      n_fail++;
      $display("FAIL b2b_load_start: got first beat at cycle %0d, expected %0d", tf, f1);
    end
    collect("b2b_second", 16, 1'b0, 1'b0, fv);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_min_values();
    test_real_imag();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
